// File: rtl/fsk_frame_slicer.sv
// FSK bit slicer: preamble hunt (1/0/1 run lengths), then majority-vote data slicing per window.
// Optional FSK_SLICER_FRAME_BUF_EN adds a frame_data output holding the bits of the last completed frame.
module fsk_frame_slicer #(
    parameter int PRE_RUN       = 150,
    parameter int PRE_ZERO_RUN  = 152,
    parameter int EOF_RUN       = 152,
    parameter int ONE_WIN       = 50,
    parameter int ZERO_WIN      = 48,
    parameter int ZERO_LONG_WIN = 56,
    parameter int LONG_EVERY    = 4,
    parameter int MAX_BITS      = 96,
    parameter int CNT_W         = 8,
    localparam int BC_W         = $clog2(MAX_BITS + 1)
) (
    input  logic            sqwv,
    input  logic            rst_n,
    input  logic            manual,
    input  logic            fsk_in,
    output logic            bit_out,
    output logic            bit_valid,
    output logic [BC_W-1:0] bit_cnt,
    output logic            frame_busy,
    output logic            frame_done,
    output logic            frame_err
`ifdef FSK_SLICER_FRAME_BUF_EN
    ,
    output logic [MAX_BITS-1:0] frame_data
`endif
);

    localparam int MAX_WIN = (ONE_WIN > ZERO_LONG_WIN) ? ONE_WIN : ZERO_LONG_WIN;
    localparam int ZI_W    = (LONG_EVERY > 1) ? $clog2(LONG_EVERY) : 1;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef enum logic [2:0] {S_HUNT, S_PRE1, S_PRE0, S_PRE2, S_DATA} state_t;
    typedef struct packed {
        cnt_t n;
        cnt_t ones;
        cnt_t zeros;
        cnt_t eof;
    } cnt_s;

    state_t          state_q, state_d;
    cnt_s            cnt_q, cnt_d;
    logic [ZI_W-1:0] zidx_q, zidx_d, zidx_wrap;
    cnt_t            n_inc, ones_inc, zeros_inc, eof_inc, zwin;
    logic            eof_hit, dec0, dec1, decide, stuck, full;
    logic            valid_d, bit_d, done_d, err_d, busy_d;
    logic [BC_W-1:0] cnt_nx;

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Every count includes the sample arriving this cycle.
    assign n_inc     = sat_inc(cnt_q.n);
    assign ones_inc  = fsk_in ? sat_inc(cnt_q.ones) : cnt_q.ones;
    assign zeros_inc = fsk_in ? cnt_q.zeros : sat_inc(cnt_q.zeros);
    assign eof_inc   = fsk_in ? '0 : sat_inc(cnt_q.eof);

    assign zwin      = (zidx_q == ZI_W'(1)) ? cnt_t'(ZERO_LONG_WIN) : cnt_t'(ZERO_WIN);
    assign zidx_wrap = (zidx_q == ZI_W'(LONG_EVERY - 1)) ? '0 : zidx_q + 1'b1;
    assign eof_hit   = eof_inc >= cnt_t'(EOF_RUN);
    assign dec0      = (n_inc == zwin) && (zeros_inc > ones_inc);
    assign dec1      = !dec0 && (n_inc == cnt_t'(ONE_WIN)) && (ones_inc > zeros_inc);
    assign decide    = dec0 || dec1;
    assign stuck     = n_inc >= cnt_t'(MAX_WIN);
    assign full      = bit_cnt == BC_W'(MAX_BITS);

    always_ff @(posedge sqwv or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_HUNT;
            cnt_q      <= '0;
            zidx_q     <= '0;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
            bit_cnt    <= '0;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            zidx_q     <= zidx_d;
            bit_out    <= bit_d;
            bit_valid  <= valid_d;
            bit_cnt    <= cnt_nx;
            frame_busy <= busy_d;
            frame_done <= done_d;
            frame_err  <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        zidx_d  = zidx_q;
        if (manual) begin
            state_d = S_HUNT;
            cnt_d   = '0;
            zidx_d  = '0;
        end else begin
            unique case (state_q)
                S_HUNT: if (fsk_in) begin
                    state_d    = S_PRE1;
                    cnt_d      = '0;
                    cnt_d.ones = cnt_t'(1);
                end
                S_PRE1: if (fsk_in) begin
                    cnt_d.ones = ones_inc;
                    if (ones_inc >= cnt_t'(PRE_RUN)) begin
                        state_d     = S_PRE0;
                        cnt_d.zeros = '0;
                    end
                end else begin
                    state_d = S_HUNT;
                    cnt_d   = '0;
                end
                // Stray ones inside the zero run restart it without abandoning the hunt.
                S_PRE0: if (!fsk_in) begin
                    cnt_d.zeros = zeros_inc;
                    if (zeros_inc >= cnt_t'(PRE_ZERO_RUN)) begin
                        state_d    = S_PRE2;
                        cnt_d.ones = '0;
                    end
                end else begin
                    cnt_d.zeros = '0;
                end
                S_PRE2: if (fsk_in) begin
                    cnt_d.ones = ones_inc;
                    if (ones_inc >= cnt_t'(PRE_RUN)) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        zidx_d  = '0;
                    end
                end else if (cnt_q.ones != '0) begin
                    state_d = S_HUNT;
                    cnt_d   = '0;
                end
                S_DATA: if (eof_hit || (decide && full) || (!decide && stuck)) begin
                    state_d = S_HUNT;
                    cnt_d   = '0;
                end else if (decide) begin
                    // eof keeps running across window boundaries.
                    cnt_d     = '0;
                    cnt_d.eof = eof_inc;
                    if (dec0) zidx_d = zidx_wrap;
                end else begin
                    cnt_d.n     = n_inc;
                    cnt_d.ones  = ones_inc;
                    cnt_d.zeros = zeros_inc;
                    cnt_d.eof   = eof_inc;
                end
                default: begin
                    state_d = S_HUNT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        valid_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        bit_d   = bit_out;
        cnt_nx  = bit_cnt;
        busy_d  = (state_d == S_DATA);
        if (manual) begin
            bit_d  = 1'b0;
            cnt_nx = '0;
        end else if (state_q == S_PRE2 && state_d == S_DATA) begin
            cnt_nx = '0;
        end else if (state_q == S_DATA) begin
            if (eof_hit) begin
                done_d = 1'b1;
            end else if (decide) begin
                if (full) begin
                    err_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    bit_d   = dec1;
                    cnt_nx  = bit_cnt + 1'b1;
                end
            end else if (stuck) begin
                err_d = 1'b1;
            end
        end
    end

`ifdef FSK_SLICER_FRAME_BUF_EN
    logic [MAX_BITS-1:0] shreg;

    always_ff @(posedge sqwv or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            frame_data <= '0;
        end else if (manual) begin
            shreg      <= '0;
            frame_data <= '0;
        end else begin
            if (valid_d) shreg <= {shreg[MAX_BITS-2:0], bit_d};
            if (done_d)  frame_data <= shreg;
        end
    end
`endif

endmodule
